mhd_sweep_ctrl: RTL and testbench

//   Sequential counterpart of the combinational Hamming-distance miter.
//   - Drives every input vector 0..2^IN_W-1 to an exact/approximate circuit pair.
//   - Collects the returned output pairs and computes the Hamming distance (HD) per vector.
//   - Flags violations (HD > MHD) and reports error count, worst HD and first failing vector.
//   - Sits between the DUT-pair harness and the approximation-evaluation top.

---
 rtl/mhd_pkg.sv | 16 +
 rtl/mhd_popcount.sv | 46 ++++
 rtl/mhd_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_mhd_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance sweep controller.
package mhd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  // Bits needed to hold a Hamming distance of 0..out_w.
  function automatic int hd_width(input int out_w);
    return $clog2(out_w + 1);
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// S1 of the result pipeline: registers popcount(exact ^ approx) together with its result index.
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic [OUT_W-1:0]              exact_i,
  input  logic [OUT_W-1:0]              approx_i,
  input  logic [IDX_W-1:0]              idx_i,
  output logic                          valid_o,
  output logic [hd_width(OUT_W)-1:0]    hd_o,
  output logic [IDX_W-1:0]              idx_o
);

  localparam int HD_W = hd_width(OUT_W);

  logic            valid_q;
  logic [HD_W-1:0] hd_d, hd_q;
  logic [IDX_W-1:0] idx_q;

  always_comb begin
    hd_d = '0;
    for (int i = 0; i < OUT_W; i++) hd_d = hd_d + HD_W'(exact_i[i] ^ approx_i[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      hd_q    <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_i;
      hd_q    <= hd_d;
      idx_q   <= idx_i;
    end
  end

  assign valid_o = valid_q;
  assign hd_o    = hd_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/mhd_sweep_ctrl.sv
// Sweeps all input vectors through an exact/approx pair and tracks Hamming-distance violations.
// Optional MHD_STOP_ON_FAIL_EN: end the sweep at the first violation.
module mhd_sweep_ctrl
  import mhd_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int MHD   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       vec_valid,
  input  logic                       vec_ready,
  output logic [IN_W-1:0]            vec_data,
  input  logic                       res_valid,
  input  logic [OUT_W-1:0]           res_exact,
  input  logic [OUT_W-1:0]           res_approx,
  output logic [IN_W:0]              err_cnt,
  output logic [hd_width(OUT_W)-1:0] max_hd,
  output logic                       fail_seen,
  output logic [IN_W-1:0]            first_fail_vec
);

  localparam int               HD_W    = hd_width(OUT_W);
  localparam logic [IN_W-1:0]  LAST    = '1;
  localparam logic [IN_W:0]    ERR_MAX = {1'b1, {IN_W{1'b0}}};

  sweep_state_t    state_q, state_d;
  logic [IN_W-1:0] vec_q, vec_d, ridx_q, ridx_d, ffv_q, ffv_d;
  logic [IN_W:0]   err_q, err_d;
  logic [HD_W-1:0] maxhd_q, maxhd_d;
  logic            fail_q, fail_d;

  logic            s1_vld;
  logic [HD_W-1:0] s1_hd;
  logic [IN_W-1:0] s1_idx;
  logic            active, s2_vld, viol, stop, fire, launch;

  mhd_popcount #(.OUT_W(OUT_W), .IDX_W(IN_W)) u_s1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (res_valid && active),
    .exact_i  (res_exact),
    .approx_i (res_approx),
    .idx_i    (ridx_q),
    .valid_o  (s1_vld),
    .hd_o     (s1_hd),
    .idx_o    (s1_idx)
  );

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // S2 is gated by state so results still in flight after a stop are discarded.
  assign s2_vld = s1_vld && active;
  assign viol   = s2_vld && (int'(s1_hd) > MHD);
`ifdef MHD_STOP_ON_FAIL_EN
  assign stop   = viol;
`else
  assign stop   = 1'b0;
`endif
  assign vec_valid = (state_q == ST_RUN) && !stop;
  assign fire      = vec_valid && vec_ready;
  assign launch    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ridx_d  = ridx_q;
    err_d   = err_q;
    maxhd_d = maxhd_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    if (launch) begin
      state_d = ST_RUN;
      vec_d   = '0;
      ridx_d  = '0;
      err_d   = '0;
      maxhd_d = '0;
      fail_d  = 1'b0;
      ffv_d   = '0;
    end else begin
      // vec_q parks on LAST after the final transfer; vec_valid is already low by then.
      if (fire) begin
        if (vec_q == LAST) state_d = ST_DRAIN;
        else               vec_d   = vec_q + IN_W'(1);
      end
      if (res_valid && active) ridx_d = ridx_q + IN_W'(1);
      if (s2_vld) begin
        if (s1_hd > maxhd_q) maxhd_d = s1_hd;
        if (viol) begin
          if (err_q != ERR_MAX) err_d = err_q + (IN_W+1)'(1);
          if (!fail_q) begin
            fail_d = 1'b1;
            ffv_d  = s1_idx;
          end
        end
        if ((state_q == ST_DRAIN) && (s1_idx == LAST)) state_d = ST_DONE;
      end
      if (stop) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      ridx_q  <= '0;
      err_q   <= '0;
      maxhd_q <= '0;
      fail_q  <= 1'b0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ridx_q  <= ridx_d;
      err_q   <= err_d;
      maxhd_q <= maxhd_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
    end
  end

  assign busy           = active;
  assign done           = (state_q == ST_DONE);
  assign vec_data       = vec_q;
  assign err_cnt        = err_q;
  assign max_hd         = maxhd_q;
  assign fail_seen      = fail_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_mhd_sweep_ctrl.sv
// Randomized scoreboard bench for mhd_sweep_ctrl: harness model, stats reference model, monitor.
`timescale 1ns/1ps
module tb_mhd_sweep_ctrl;
  import mhd_pkg::*;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;
  localparam int MHD   = 4;
  localparam int NV    = 1 << IN_W;
  localparam int HD_W  = hd_width(OUT_W);

  logic clk = 1'b0;
  logic rst, start, vec_ready, res_valid;
  logic busy, done, vec_valid, fail_seen;
  logic [IN_W-1:0]  vec_data, first_fail_vec;
  logic [OUT_W-1:0] res_exact, res_approx;
  logic [IN_W:0]    err_cnt;
  logic [HD_W-1:0]  max_hd;

  typedef struct packed { int err; int mhd; int fail; int ffv; } stats_t;
  typedef struct packed { int v; int due; } pend_t;

  int checks = 0, failures = 0, cyc = 0;
  stats_t exp_q[$];
  int     exp_vec_q[$];
  pend_t  pend[$];
  logic [OUT_W-1:0] mask [NV];
  int ready_mode = 0, hold_cnt = 0, last_res_cyc = -1, last_due = 0;
  bit inject = 1'b0;

  mhd_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .MHD(MHD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .res_valid(res_valid), .res_exact(res_exact), .res_approx(res_approx),
    .err_cnt(err_cnt), .max_hd(max_hd), .fail_seen(fail_seen),
    .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: statistics follow directly from the per-vector HD of the masks.
  function automatic stats_t model();
    stats_t s;
    s = '0;
    for (int i = 0; i < NV; i++) begin
      int hd;
      hd = $countones(mask[i]);
      if (hd > s.mhd) s.mhd = hd;
      if (hd > MHD) begin
        s.err++;
        if (s.fail == 0) begin s.fail = 1; s.ffv = i; end
`ifdef MHD_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    return s;
  endfunction

  // Harness: returns approx = exact ^ mask[v] for each accepted vector, in order, after 1..3 cycles.
  initial begin
    vec_ready = 1'b0; res_valid = 1'b0; res_exact = '0; res_approx = '0;
    forever begin
      pend_t p;
      @(negedge clk);
      res_valid  = 1'b0;
      res_exact  = OUT_W'($urandom);
      res_approx = OUT_W'($urandom);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        res_valid  = 1'b1;
        res_approx = res_exact ^ mask[p.v];
        if (p.v == NV-1) last_res_cyc = cyc;
      end else if (inject && pend.size() == 0) begin
        res_valid = 1'b1; res_exact = '0; res_approx = '1; inject = 1'b0;
      end
      case (ready_mode)
        0: vec_ready = 1'b1;
        1: vec_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (vec_valid === 1'b1 && vec_data == IN_W'(3) && hold_cnt < 3) begin
            vec_ready = 1'b0; hold_cnt++;
          end else vec_ready = 1'b1;
        end
      endcase
      if (vec_valid === 1'b1 && vec_ready && !rst) begin
        p.v   = int'(vec_data);
        p.due = cyc + 1 + int'($urandom_range(0, 2));
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        pend.push_back(p);
      end
    end
  end

  // Monitor: vector order/stability per transfer, stats on each rising done.
  initial begin
    bit done_d, stall;
    logic [IN_W-1:0] stall_v;
    stats_t e;
    done_d = 1'b0; stall = 1'b0; stall_v = '0;
    forever begin
      @(negedge clk); #1;
      if (stall) begin
        check("hold_valid", vec_valid, 1);
        check("hold_data", vec_data, stall_v);
      end
`ifndef MHD_STOP_ON_FAIL_EN
      stall = (vec_valid === 1'b1) && !vec_ready && !rst;
`endif
      stall_v = vec_data;
      if (vec_valid === 1'b1 && vec_ready && !rst) begin
        if (exp_vec_q.size() > 0) check("vec_order", vec_data, exp_vec_q.pop_front());
        else check("vec_extra", vec_data, -1);
      end
      if (done === 1'b1 && !done_d) begin
        if (exp_q.size() == 0) check("done_unexpected", done, 0);
        else begin
          e = exp_q.pop_front();
          check("err_cnt", err_cnt, e.err);
          check("max_hd", max_hd, e.mhd);
          check("fail_seen", fail_seen, e.fail);
          check("first_fail_vec", first_fail_vec, e.ffv);
`ifndef MHD_STOP_ON_FAIL_EN
          check("vec_missing", exp_vec_q.size(), 0);
          check("done_latency", cyc - last_res_cyc, 2);
`endif
          exp_vec_q.delete();
        end
      end
      done_d = (done === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    pend.delete(); exp_vec_q.delete(); exp_q.delete();
    check("reset_outputs",
          {busy, done, vec_valid, vec_data, err_cnt, max_hd, fail_seen, first_fail_vec}, 0);
  endtask

  task automatic begin_sweep(input int mode);
    ready_mode = mode; hold_cnt = 0;
    exp_q.push_back(model());
    for (int i = 0; i < NV; i++) exp_vec_q.push_back(i);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_sweep(input int mode, input bit mid_start, input bit probe);
    stats_t e;
    int n;
    e = model();
    begin_sweep(mode);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      start = (mid_start && n == 3);
      tick(); n++;
    end
    start = 1'b0;
    check("sweep_done", done, 1);
    if (done !== 1'b1) do_reset();
    n = 0;
    while (pend.size() > 0 && n < 50) begin tick(); n++; end
    tick(); tick();
    if (probe) begin
      inject = 1'b1;
      repeat (5) tick();
      check("late_res_err", err_cnt, e.err);
      check("late_res_max", max_hd, e.mhd);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < NV; i++) mask[i] = '0;
    tick(); tick();
    do_reset();

    run_sweep(0, 1'b0, 1'b1);                          // all equal, late result probe
    mask[5] = 8'h1F; run_sweep(0, 1'b0, 1'b0);         // single HD 5
    for (int i = 0; i < NV; i++) mask[i] = 8'h0F;
    run_sweep(0, 1'b0, 1'b0);                          // HD 4 everywhere: boundary
    for (int i = 0; i < NV; i++) mask[i] = OUT_W'($urandom);
    run_sweep(2, 1'b0, 1'b0);                          // stall at vector 3

    begin_sweep(0);                                    // abort at vector 4
    n = 0;
    while (!(vec_valid === 1'b1 && vec_data == IN_W'(4)) && n < 100) begin tick(); n++; end
    check("reach_vec4", vec_data, 4);
    do_reset();
    run_sweep(1, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) mask[i] = '0;
    mask[2] = 8'h3F; mask[6] = 8'h3F;
    run_sweep(0, 1'b0, 1'b0);                          // HD 6 at vectors 2 and 6

    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < NV; i++) mask[i] = OUT_W'($urandom);
      run_sweep(1, (s == 1), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
